// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register with EX-stage operand forwarding for the RV32I core.
// Captures decoded operands/control every edge (reset > flush > stall > load)
// and resolves rs1/rs2 against the in-flight EX/MEM and MEM/WB results.
// Build option: define ID_EX_FWD_EN to enable the forwarding muxes. Without it,
// operands come straight from the registered regfile data, fwd selects read 00,
// and the hazard unit is expected to stall instead.
module id_ex_operand_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [3:0]  alu_op_i,
    input  logic        use_imm_i,
    input  logic        use_pc_i,
    input  logic        reg_wen_i,
    input  logic [4:0]  exm_rd_i,
    input  logic        exm_wen_i,
    input  logic [31:0] exm_data_i,
    input  logic [4:0]  mwb_rd_i,
    input  logic        mwb_wen_i,
    input  logic [31:0] mwb_data_i,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    output logic [31:0] store_data_o,
    output logic [31:0] pc_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_addr_o,
    output logic [3:0]  alu_op_o,
    output logic        reg_wen_o,
    output logic        valid_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MWB  = 2'b01;
    localparam logic [1:0] FWD_EXM  = 2'b10;

    // Stage registers and their next-state values
    logic [31:0] pc_q, pc_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [31:0] rs2_data_q, rs2_data_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs1_addr_q, rs1_addr_d;
    logic [4:0]  rs2_addr_q, rs2_addr_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        use_imm_q, use_imm_d;
    logic        use_pc_q, use_pc_d;
    logic        reg_wen_q, reg_wen_d;
    logic        valid_q, valid_d;

    // Resolved sources
    logic [31:0] fwd_rs1_s;
    logic [31:0] fwd_rs2_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;

    // Next-state selection: flush loads a bubble, stall holds, otherwise load ID
    always_comb begin
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        alu_op_d   = alu_op_q;
        use_imm_d  = use_imm_q;
        use_pc_d   = use_pc_q;
        reg_wen_d  = reg_wen_q;
        valid_d    = valid_q;
        if (flush_i) begin
            pc_d       = 32'd0;
            rs1_data_d = 32'd0;
            rs2_data_d = 32'd0;
            imm_d      = 32'd0;
            rs1_addr_d = 5'd0;
            rs2_addr_d = 5'd0;
            rd_addr_d  = 5'd0;
            alu_op_d   = 4'd0;
            use_imm_d  = 1'b0;
            use_pc_d   = 1'b0;
            reg_wen_d  = 1'b0;
            valid_d    = 1'b0;
        end else if (stall_i) begin
            // hold: defaults already carry the current contents
            valid_d    = valid_q;
        end else begin
            pc_d       = pc_i;
            rs1_data_d = rs1_data_i;
            rs2_data_d = rs2_data_i;
            imm_d      = imm_i;
            rs1_addr_d = rs1_addr_i;
            rs2_addr_d = rs2_addr_i;
            rd_addr_d  = rd_addr_i;
            alu_op_d   = alu_op_i;
            use_imm_d  = use_imm_i;
            use_pc_d   = use_pc_i;
            reg_wen_d  = reg_wen_i;
            valid_d    = valid_i;
        end
    end

    // Stage register bank with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= 32'd0;
            rs1_data_q <= 32'd0;
            rs2_data_q <= 32'd0;
            imm_q      <= 32'd0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            rd_addr_q  <= 5'd0;
            alu_op_q   <= 4'd0;
            use_imm_q  <= 1'b0;
            use_pc_q   <= 1'b0;
            reg_wen_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            alu_op_q   <= alu_op_d;
            use_imm_q  <= use_imm_d;
            use_pc_q   <= use_pc_d;
            reg_wen_q  <= reg_wen_d;
            valid_q    <= valid_d;
        end
    end

`ifdef ID_EX_FWD_EN
    logic exm_hit_a_s, mwb_hit_a_s, exm_hit_b_s, mwb_hit_b_s;

    // x0 never matches, so a zero source always reads the registered (zero) data
    assign exm_hit_a_s = exm_wen_i && (exm_rd_i != 5'd0) && (exm_rd_i == rs1_addr_q);
    assign mwb_hit_a_s = mwb_wen_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == rs1_addr_q);
    assign exm_hit_b_s = exm_wen_i && (exm_rd_i != 5'd0) && (exm_rd_i == rs2_addr_q);
    assign mwb_hit_b_s = mwb_wen_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == rs2_addr_q);

    // rs1 forwarding: youngest producer (EX/MEM) wins over MEM/WB
    always_comb begin
        fwd_rs1_s = rs1_data_q;
        fwd_a_s   = FWD_NONE;
        if (exm_hit_a_s) begin
            fwd_rs1_s = exm_data_i;
            fwd_a_s   = FWD_EXM;
        end else if (mwb_hit_a_s) begin
            fwd_rs1_s = mwb_data_i;
            fwd_a_s   = FWD_MWB;
        end else begin
            fwd_rs1_s = rs1_data_q;
            fwd_a_s   = FWD_NONE;
        end
    end

    // rs2 forwarding: same rule as rs1
    always_comb begin
        fwd_rs2_s = rs2_data_q;
        fwd_b_s   = FWD_NONE;
        if (exm_hit_b_s) begin
            fwd_rs2_s = exm_data_i;
            fwd_b_s   = FWD_EXM;
        end else if (mwb_hit_b_s) begin
            fwd_rs2_s = mwb_data_i;
            fwd_b_s   = FWD_MWB;
        end else begin
            fwd_rs2_s = rs2_data_q;
            fwd_b_s   = FWD_NONE;
        end
    end
`else
    logic unused_fwd_inputs_s;

    // Forwarding disabled: sources come straight from the stage registers
    always_comb begin
        fwd_rs1_s = rs1_data_q;
        fwd_rs2_s = rs2_data_q;
        fwd_a_s   = FWD_NONE;
        fwd_b_s   = FWD_NONE;
    end

    // Forwarding inputs and source addresses have no consumer in this build
    assign unused_fwd_inputs_s = ^{exm_rd_i, exm_wen_i, exm_data_i,
                                   mwb_rd_i, mwb_wen_i, mwb_data_i,
                                   rs1_addr_q, rs2_addr_q, FWD_MWB, FWD_EXM};
`endif

    // ALU operand selection; store data always takes the forwarded rs2
    always_comb begin
        operand_a_o  = fwd_rs1_s;
        operand_b_o  = fwd_rs2_s;
        store_data_o = fwd_rs2_s;
        if (use_pc_q) begin
            operand_a_o = pc_q;
        end else begin
            operand_a_o = fwd_rs1_s;
        end
        if (use_imm_q) begin
            operand_b_o = imm_q;
        end else begin
            operand_b_o = fwd_rs2_s;
        end
    end

    assign pc_o      = pc_q;
    assign imm_o     = imm_q;
    assign rd_addr_o = rd_addr_q;
    assign alu_op_o  = alu_op_q;
    assign reg_wen_o = reg_wen_q & valid_q;
    assign valid_o   = valid_q;
    assign fwd_a_o   = fwd_a_s;
    assign fwd_b_o   = fwd_b_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed test-plan cases with
// literal expectations plus randomized traffic checked every cycle against a
// behavioural model of the ID/EX slot.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [3:0]  alu_op_i;
    logic        use_imm_i, use_pc_i, reg_wen_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic        exm_wen_i, mwb_wen_i;
    logic [31:0] exm_data_i, mwb_data_i;
    logic [31:0] operand_a_o, operand_b_o, store_data_o, pc_o, imm_o;
    logic [4:0]  rd_addr_o;
    logic [3:0]  alu_op_o;
    logic        reg_wen_o, valid_o;
    logic [1:0]  fwd_a_o, fwd_b_o;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .alu_op_i(alu_op_i),
        .use_imm_i(use_imm_i), .use_pc_i(use_pc_i), .reg_wen_i(reg_wen_i),
        .exm_rd_i(exm_rd_i), .exm_wen_i(exm_wen_i), .exm_data_i(exm_data_i),
        .mwb_rd_i(mwb_rd_i), .mwb_wen_i(mwb_wen_i), .mwb_data_i(mwb_data_i),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .store_data_o(store_data_o), .pc_o(pc_o), .imm_o(imm_o),
        .rd_addr_o(rd_addr_o), .alu_op_o(alu_op_o), .reg_wen_o(reg_wen_o),
        .valid_o(valid_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    // Model of the instruction held in the ID/EX slot
    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  a1, a2, rd;
        logic [3:0]  op;
        logic        ui, up, wen, v;
    } slot_t;

    slot_t slot;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i)        slot <= '0;
        else if (flush_i) slot <= '0;
        else if (!stall_i)
            slot <= '{pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i,
                      rd_addr_i, alu_op_i, use_imm_i, use_pc_i, reg_wen_i, valid_i};
    end

    // Value a source register must read, with its forward select in the top bits
    function automatic logic [33:0] resolve(input logic [4:0] a, input logic [31:0] d);
        if (FWD && exm_wen_i && exm_rd_i != 5'd0 && exm_rd_i == a) return {2'b10, exm_data_i};
        if (FWD && mwb_wen_i && mwb_rd_i != 5'd0 && mwb_rd_i == a) return {2'b01, mwb_data_i};
        return {2'b00, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [33:0] r1, r2;
        r1 = resolve(slot.a1, slot.rs1d);
        r2 = resolve(slot.a2, slot.rs2d);
        check("model_op_a",  operand_a_o, slot.up ? slot.pc  : r1[31:0]);
        check("model_op_b",  operand_b_o, slot.ui ? slot.imm : r2[31:0]);
        check("model_store", store_data_o, r2[31:0]);
        check("model_pc",    pc_o, slot.pc);
        check("model_imm",   imm_o, slot.imm);
        check("model_rd",    {27'd0, rd_addr_o}, {27'd0, slot.rd});
        check("model_aluop", {28'd0, alu_op_o}, {28'd0, slot.op});
        check("model_wen",   {31'd0, reg_wen_o}, {31'd0, slot.wen & slot.v});
        check("model_valid", {31'd0, valid_o}, {31'd0, slot.v});
        check("model_fwd_a", {30'd0, fwd_a_o}, {30'd0, r1[33:32]});
        check("model_fwd_b", {30'd0, fwd_b_o}, {30'd0, r2[33:32]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        pc_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0; imm_i = 32'd0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; rd_addr_i = 5'd0; alu_op_i = 4'd0;
        use_imm_i = 1'b0; use_pc_i = 1'b0; reg_wen_i = 1'b0;
        exm_rd_i = 5'd0; exm_wen_i = 1'b0; exm_data_i = 32'd0;
        mwb_rd_i = 5'd0; mwb_wen_i = 1'b0; mwb_data_i = 32'd0;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        #1;
        check("reset_pc", pc_o, 32'd0);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        tick(); tick();
        rst_i = 1'b0;

        // First load after reset
        pc_i = 32'h100; valid_i = 1'b1; reg_wen_i = 1'b1; rd_addr_i = 5'd4; alu_op_i = 4'd3;
        tick();
        check("load_pc", pc_o, 32'h100);
        check("load_wen", {31'd0, reg_wen_o}, 32'd1);

        // EX/MEM forward to rs1
        rs1_addr_i = 5'd5; rs1_data_i = 32'h1234;
        tick();
        exm_wen_i = 1'b1; exm_rd_i = 5'd5; exm_data_i = 32'hDEADBEEF;
        #1;
        check("exm_fwd_a", operand_a_o, FWD ? 32'hDEADBEEF : 32'h1234);
        check("exm_fwd_sel", {30'd0, fwd_a_o}, FWD ? 32'd2 : 32'd0);

        // Both stages hit x7: EX/MEM wins; then MEM/WB alone
        rs1_addr_i = 5'd7; rs1_data_i = 32'h77; exm_wen_i = 1'b0;
        tick();
        exm_wen_i = 1'b1; exm_rd_i = 5'd7; exm_data_i = 32'h11;
        mwb_wen_i = 1'b1; mwb_rd_i = 5'd7; mwb_data_i = 32'h22;
        #1;
        check("prio_exm", operand_a_o, FWD ? 32'h11 : 32'h77);
        exm_wen_i = 1'b0;
        #1;
        check("mwb_only", operand_a_o, FWD ? 32'h22 : 32'h77);
        check("mwb_only_sel", {30'd0, fwd_a_o}, FWD ? 32'd1 : 32'd0);

        // x0 is never forwarded
        rs1_addr_i = 5'd0; rs1_data_i = 32'd0;
        exm_wen_i = 1'b1; exm_rd_i = 5'd0; exm_data_i = 32'hFFFFFFFF;
        mwb_wen_i = 1'b1; mwb_rd_i = 5'd0; mwb_data_i = 32'hFFFFFFFF;
        tick();
        check("x0_op_a", operand_a_o, 32'd0);
        check("x0_sel", {30'd0, fwd_a_o}, 32'd0);

        // Immediate on B, forwarded rs2 still drives store data
        use_imm_i = 1'b1; imm_i = 32'hFFFFF800; rs2_addr_i = 5'd3; rs2_data_i = 32'h33;
        exm_wen_i = 1'b0; mwb_wen_i = 1'b1; mwb_rd_i = 5'd3; mwb_data_i = 32'h55;
        tick();
        check("imm_op_b", operand_b_o, 32'hFFFFF800);
        check("imm_store", store_data_o, FWD ? 32'h55 : 32'h33);
        check("imm_sel_b", {30'd0, fwd_b_o}, FWD ? 32'd1 : 32'd0);

        // Stall three cycles with changing ID inputs
        use_imm_i = 1'b0; mwb_wen_i = 1'b0;
        pc_i = 32'h200; rd_addr_i = 5'd9; valid_i = 1'b1; reg_wen_i = 1'b1;
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_i = $urandom; rd_addr_i = 5'($urandom_range(10, 31));
            tick();
            check("stall_pc", pc_o, 32'h200);
            check("stall_rd", {27'd0, rd_addr_o}, 32'd9);
        end

        // Flush beats stall
        flush_i = 1'b1;
        tick();
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_wen", {31'd0, reg_wen_o}, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;

        // Reset asserted mid-stall with live inputs
        pc_i = 32'h300; valid_i = 1'b1; reg_wen_i = 1'b1; rs1_addr_i = 5'd6;
        tick();
        stall_i = 1'b1;
        exm_wen_i = 1'b1; exm_rd_i = 5'd6; exm_data_i = 32'hCAFE0001;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_pc", pc_o, 32'd0);
        check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        check("rst_mid_op_a", operand_a_o, 32'd0);
        tick();
        rst_i = 1'b0; stall_i = 1'b0; exm_wen_i = 1'b0; pc_i = 32'h400;
        tick();
        check("post_rst_pc", pc_o, 32'h400);

        // Producer retires from EX/MEM to MEM/WB during a stall
        rs1_addr_i = 5'd9; rs1_data_i = 32'h99; use_pc_i = 1'b0;
        tick();
        stall_i = 1'b1;
        exm_wen_i = 1'b1; exm_rd_i = 5'd9; exm_data_i = 32'hAA;
        #1;
        check("retire_exm", operand_a_o, FWD ? 32'hAA : 32'h99);
        tick();
        exm_wen_i = 1'b0; mwb_wen_i = 1'b1; mwb_rd_i = 5'd9; mwb_data_i = 32'hAA;
        #1;
        check("retire_mwb", operand_a_o, FWD ? 32'hAA : 32'h99);
        check("retire_sel", {30'd0, fwd_a_o}, FWD ? 32'd1 : 32'd0);
        stall_i = 1'b0;

        // Randomized traffic, checked by the every-cycle comparison
        for (int i = 0; i < 400; i++) begin
            tick();
            stall_i    = ($urandom_range(0, 9) < 2);
            flush_i    = ($urandom_range(0, 9) < 1);
            valid_i    = 1'($urandom);
            pc_i       = $urandom;
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            rs1_data_i = (rs1_addr_i == 5'd0) ? 32'd0 : $urandom;
            rs2_data_i = (rs2_addr_i == 5'd0) ? 32'd0 : $urandom;
            imm_i      = $urandom;
            rd_addr_i  = 5'($urandom);
            alu_op_i   = 4'($urandom);
            use_imm_i  = 1'($urandom);
            use_pc_i   = 1'($urandom);
            reg_wen_i  = 1'($urandom);
            exm_rd_i   = 5'($urandom_range(0, 7));
            exm_wen_i  = 1'($urandom);
            exm_data_i = $urandom;
            mwb_rd_i   = 5'($urandom_range(0, 7));
            mwb_wen_i  = 1'($urandom);
            mwb_data_i = $urandom;
        end
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register plus EX-stage operand forwarding for the pipelined RV32I core. It captures decoded operands and control each cycle, then presents final ALU operands `operand_a_o`/`operand_b_o` to the 32-bit ALU datapath (adder, `xor_32bit`, shifters, compare). Operands are resolved against in-flight EX/MEM and MEM/WB results. It supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

## Interface
- No parameters; all datapaths are 32 bits, register addresses are 5 bits.
- `clk_i` in 1: core clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `stall_i` in 1: hold all stage registers.
- `flush_i` in 1: load a bubble on the next edge.
- `valid_i` in 1: ID slot holds a real instruction.
- `pc_i` in 32: PC of the ID instruction.
- `rs1_data_i`, `rs2_data_i` in 32 each: regfile read data.
- `imm_i` in 32: sign-extended immediate.
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i` in 5 each: register indices.
- `alu_op_i` in 4: ALU function code, passed through.
- `use_imm_i` in 1: operand B selects the immediate.
- `use_pc_i` in 1: operand A selects the PC (AUIPC/JAL).
- `reg_wen_i` in 1: instruction writes rd.
- `exm_rd_i` in 5, `exm_wen_i` in 1, `exm_data_i` in 32: EX/MEM result.
- `mwb_rd_i` in 5, `mwb_wen_i` in 1, `mwb_data_i` in 32: MEM/WB result.
- `operand_a_o`, `operand_b_o` out 32: ALU operands.
- `store_data_o` out 32: forwarded rs2, used for stores.
- `pc_o` out 32, `imm_o` out 32, `rd_addr_o` out 5, `alu_op_o` out 4, `reg_wen_o` out 1, `valid_o` out 1: registered pass-through fields.
- `fwd_a_o`, `fwd_b_o` out 2: forward select, 00 = none, 01 = MEM/WB, 10 = EX/MEM. For debug and coverage.

## Operation
- Registered fields: `pc`, `rs1_data`, `rs2_data`, `imm`, `rs1_addr`, `rs2_addr`, `rd_addr`, `alu_op`, `use_imm`, `use_pc`, `reg_wen`, `valid`.
- Per-edge priority: reset > flush > stall > load.
  - Flush clears every registered field to 0, so `valid`=0 and `reg_wen`=0.
  - Stall holds every registered field.
- `reg_wen_o` = registered `reg_wen` AND registered `valid`. A bubble never writes.
- Forwarding is combinational from registered addresses to outputs. For source S ∈ {rs1, rs2}:
  - EX/MEM hit: `exm_wen_i` && `exm_rd_i`!=0 && `exm_rd_i`==S_addr → `exm_data_i`, sel 10.
  - Otherwise MEM/WB hit with the same rule → `mwb_data_i`, sel 01.
  - Otherwise registered S_data, sel 00.
  - EX/MEM wins when both hit.
- Source x0 is never forwarded. Output is the registered data, which the regfile guarantees is 0.
- `operand_a_o` = `use_pc` ? registered `pc` : fwd_rs1.
- `operand_b_o` = `use_imm` ? registered `imm` : fwd_rs2.
- `store_data_o` = fwd_rs2 always, regardless of `use_imm`.
- Forwarding is evaluated even when `valid`=0. Downstream qualifies with `valid_o`.

## Timing
- Latency: ID inputs appear on the registered outputs 1 cycle after a non-stalled, non-flushed edge.
- Forwarding inputs to operand outputs: same cycle, purely combinational, no added latency.
- Reset values (asynchronous, immediate on `rst_i` assertion): all outputs 0, `valid_o`=0, `fwd_a_o`=`fwd_b_o`=00.
- Simultaneous `flush_i` and `stall_i`: flush wins, bubble loaded.
- `rst_i` asserted mid-stall: registers clear immediately. After release, the first edge with `stall_i`=0 loads ID inputs.
- Stall holds registered fields only. Operand outputs track the forwarding inputs while stalled, so a producer that retires during the stall is picked up from MEM/WB.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding muxes as described.
- `ID_EX_FWD_EN` undefined:
  - Forwarding muxes removed; fwd_rs1/fwd_rs2 = registered data.
  - `fwd_a_o`=`fwd_b_o`=00 constant.
  - Forwarding inputs unused; the hazard unit must stall instead.
- All other behaviour identical in both builds.

## Test plan
- Reset: assert `rst_i` mid-cycle with live inputs → all outputs 0 immediately. Release, then load `pc_i`=0x100 → `pc_o`=0x100 next edge.
- EX/MEM forward: registered rs1=x5; `exm_wen_i`=1, `exm_rd_i`=5, `exm_data_i`=0xDEADBEEF → `operand_a_o`=0xDEADBEEF, `fwd_a_o`=10.
- Priority and x0:
  - EX/MEM and MEM/WB both target x7 (0x11, 0x22) → 0x11.
  - Both target x0 with 0xFFFFFFFF and rs1=x0 → `operand_a_o`=0, `fwd_a_o`=00.
- Immediate/store: `use_imm_i`=1, `imm_i`=0xFFFFF800, rs2=x3 forwarded from MEM/WB as 0x55 → `operand_b_o`=0xFFFFF800, `store_data_o`=0x55, `fwd_b_o`=01.
- Stall then flush:
  - Stall 3 cycles while ID inputs change → outputs held.
  - `flush_i`+`stall_i` together → `valid_o`=0, `reg_wen_o`=0 next edge.
- Build without `ID_EX_FWD_EN`: the EX/MEM hit stimulus yields registered `rs1_data` (0x1234), `fwd_a_o`=00.
